// File: rtl/ascon_ctrl_fsm.sv
// ASCON-128 encryption sequencer: steps permutation_final through init, AD, PT and finalization,
// requesting one data block per absorb cycle and stalling while the feeder has none.
module ascon_ctrl_fsm #(
  parameter int NB_AD = 1,
  parameter int NB_PT = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  output logic       select_o,
  output logic       enable_o,
  output logic [3:0] round_o,
  output logic [1:0] etat_up_o,
  output logic [1:0] etat_down_o,
  output logic       enable_cipher_o,
  output logic       enable_tag_o,
  output logic       data_req_o,
  output logic [7:0] block_idx_o,
  output logic       busy_o,
  output logic       done_o
);

  // state | meaning
  // IDLE  | waiting for start_i
  // INIT  | p12 on IV||K||N, key XOR after last round
  // AD    | p6 per associated-data block, domain bit after last block
  // PT    | p6 per plaintext block except the last
  // FINAL | last PT block absorbed with key, p12, tag capture
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_AD, S_PT, S_FINAL, S_DONE
  } state_t;

  localparam logic [7:0] LAST_AD = 8'(NB_AD - 1);
  localparam logic [7:0] LAST_PT = 8'(NB_PT - 1);

  state_t     state, state_n;
  logic [3:0] rnd, rnd_n;
  logic [7:0] blk, blk_n;
  logic       absorb, stall;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state <= S_IDLE;
      rnd   <= 4'd0;
      blk   <= 8'd0;
    end else begin
      state <= state_n;
      rnd   <= rnd_n;
      blk   <= blk_n;
    end
  end

  always_comb begin
    state_n         = state;
    rnd_n           = rnd;
    blk_n           = blk;
    select_o        = 1'b0;
    enable_o        = 1'b0;
    round_o         = 4'd0;
    etat_up_o       = 2'd0;
    etat_down_o     = 2'd0;
    enable_cipher_o = 1'b0;
    enable_tag_o    = 1'b0;
    data_req_o      = 1'b0;
    block_idx_o     = 8'd0;
    busy_o          = 1'b0;
    done_o          = 1'b0;

    absorb = ((state == S_AD || state == S_PT) && rnd == 4'd6) ||
             (state == S_FINAL && rnd == 4'd0);
    stall  = absorb && !data_valid_i;

    case (state)
      S_IDLE: begin
        if (start_i) begin
          state_n = S_INIT;
          rnd_n   = 4'd0;
          blk_n   = 8'd0;
        end
      end
      S_INIT: begin
        busy_o   = 1'b1;
        enable_o = 1'b1;
        round_o  = rnd;
        select_o = (rnd == 4'd0);
        if (rnd == 4'd11) begin
          etat_down_o = 2'd1;
          state_n     = S_AD;
          rnd_n       = 4'd6;
          blk_n       = 8'd0;
        end else begin
          rnd_n = rnd + 4'd1;
        end
      end
      S_AD: begin
        busy_o   = 1'b1;
        round_o  = rnd;
        enable_o = !stall;
        if (absorb) begin
          data_req_o  = 1'b1;
          block_idx_o = blk;
          etat_up_o   = stall ? 2'd0 : 2'd1;
        end
        if (rnd == 4'd11) begin
          if (blk == LAST_AD) begin
            etat_down_o = 2'd2;
            blk_n       = 8'd0;
            // a single PT block is absorbed directly by finalization
            if (NB_PT == 1) begin
              state_n = S_FINAL;
              rnd_n   = 4'd0;
            end else begin
              state_n = S_PT;
              rnd_n   = 4'd6;
            end
          end else begin
            blk_n = blk + 8'd1;
            rnd_n = 4'd6;
          end
        end else if (!stall) begin
          rnd_n = rnd + 4'd1;
        end
      end
      S_PT: begin
        busy_o   = 1'b1;
        round_o  = rnd;
        enable_o = !stall;
        if (absorb) begin
          data_req_o      = 1'b1;
          block_idx_o     = blk;
          etat_up_o       = stall ? 2'd0 : 2'd1;
          enable_cipher_o = !stall;
        end
        if (rnd == 4'd11) begin
          if (blk + 8'd1 == LAST_PT) begin
            state_n = S_FINAL;
            rnd_n   = 4'd0;
            blk_n   = 8'd0;
          end else begin
            blk_n = blk + 8'd1;
            rnd_n = 4'd6;
          end
        end else if (!stall) begin
          rnd_n = rnd + 4'd1;
        end
      end
      S_FINAL: begin
        busy_o   = 1'b1;
        round_o  = rnd;
        enable_o = !stall;
        if (absorb) begin
          data_req_o      = 1'b1;
          block_idx_o     = LAST_PT;
          etat_up_o       = stall ? 2'd0 : 2'd3;
          enable_cipher_o = !stall;
        end
        if (rnd == 4'd11) begin
          etat_down_o  = 2'd1;
          enable_tag_o = 1'b1;
          state_n      = S_DONE;
          rnd_n        = 4'd0;
        end else if (!stall) begin
          rnd_n = rnd + 4'd1;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_n = S_IDLE;
      end
      default: begin
        state_n = S_IDLE;
        rnd_n   = 4'd0;
        blk_n   = 8'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Bench for ascon_ctrl_fsm: two instances (default params and NB_AD=2/NB_PT=1) checked every cycle
// against a schedule-based model, plus directed runs with literal counts.
module tb_ascon_ctrl_fsm;

  logic       clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] start = 2'b00;
  logic [1:0] valid = 2'b11;
  logic [1:0] sel, en, ciph, tag, req, busy, done;
  logic [3:0] rnd [2];
  logic [1:0] up [2];
  logic [1:0] down [2];
  logic [7:0] idx [2];

  always #5 clk = ~clk;

  ascon_ctrl_fsm #(.NB_AD(1), .NB_PT(4)) dut0 (
    .clock_i(clk), .reset_i(rst[0]), .start_i(start[0]), .data_valid_i(valid[0]),
    .select_o(sel[0]), .enable_o(en[0]), .round_o(rnd[0]), .etat_up_o(up[0]),
    .etat_down_o(down[0]), .enable_cipher_o(ciph[0]), .enable_tag_o(tag[0]),
    .data_req_o(req[0]), .block_idx_o(idx[0]), .busy_o(busy[0]), .done_o(done[0])
  );

  ascon_ctrl_fsm #(.NB_AD(2), .NB_PT(1)) dut1 (
    .clock_i(clk), .reset_i(rst[1]), .start_i(start[1]), .data_valid_i(valid[1]),
    .select_o(sel[1]), .enable_o(en[1]), .round_o(rnd[1]), .etat_up_o(up[1]),
    .etat_down_o(down[1]), .enable_cipher_o(ciph[1]), .enable_tag_o(tag[1]),
    .data_req_o(req[1]), .block_idx_o(idx[1]), .busy_o(busy[1]), .done_o(done[1])
  );

  // One entry per non-stalled cycle of a run, in order.
  typedef struct packed {
    logic [3:0] rnd;
    logic       sel;
    logic [1:0] up;
    logic [1:0] down;
    logic       ciph;
    logic       tag;
    logic       absorb;
    logic [7:0] idx;
  } step_t;

  step_t sched [2][64];
  int    len [2];
  int    mode [2];   // 0 idle, 1 running, 2 done cycle
  int    ptr [2];

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  int res_en, res_ci, res_tag, res_sel, res_done, res_idx;
  logic [22:0] res_vec;

  function automatic void add(int k, int r, bit s, int u, int d, bit c, bit t, bit a, int ix);
    step_t st;
    st.rnd = 4'(r); st.sel = s; st.up = 2'(u); st.down = 2'(d);
    st.ciph = c; st.tag = t; st.absorb = a; st.idx = 8'(ix);
    sched[k][len[k]] = st;
    len[k]++;
  endfunction

  function automatic void build(int k, int nad, int npt);
    len[k] = 0;
    for (int r = 0; r < 12; r++) add(k, r, r == 0, 0, (r == 11) ? 1 : 0, 0, 0, 0, 0);
    for (int b = 0; b < nad; b++)
      for (int r = 6; r < 12; r++)
        add(k, r, 0, (r == 6) ? 1 : 0, (b == nad - 1 && r == 11) ? 2 : 0, 0, 0, r == 6, (r == 6) ? b : 0);
    for (int b = 0; b < npt - 1; b++)
      for (int r = 6; r < 12; r++)
        add(k, r, 0, (r == 6) ? 1 : 0, 0, r == 6, 0, r == 6, (r == 6) ? b : 0);
    for (int r = 0; r < 12; r++)
      add(k, r, 0, (r == 0) ? 3 : 0, (r == 11) ? 1 : 0, r == 0, r == 11, r == 0, (r == 0) ? npt - 1 : 0);
  endfunction

  function automatic logic [22:0] act_vec(int k);
    return {sel[k], en[k], rnd[k], up[k], down[k], ciph[k], tag[k], req[k], idx[k], busy[k], done[k]};
  endfunction

  function automatic logic [22:0] exp_vec(int k);
    step_t s;
    logic  st;
    if (mode[k] == 2) return 23'd1;
    if (mode[k] != 1) return 23'd0;
    s  = sched[k][ptr[k]];
    st = s.absorb && !valid[k];
    return {s.sel, !st, s.rnd, st ? 2'd0 : s.up, st ? 2'd0 : s.down, s.ciph && !st,
            s.tag, s.absorb, s.idx, 1'b1, 1'b0};
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst[k]) begin
        mode[k] <= 0;
        ptr[k]  <= 0;
      end else if (mode[k] == 0) begin
        if (start[k]) begin
          mode[k] <= 1;
          ptr[k]  <= 0;
        end
      end else if (mode[k] == 1) begin
        if (!(sched[k][ptr[k]].absorb && !valid[k])) begin
          if (ptr[k] == len[k] - 1) mode[k] <= 2;
          else ptr[k] <= ptr[k] + 1;
        end
      end else begin
        mode[k] <= 0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_run(input int k, input int stall_n, input bit extra, input int rst_at, input int maxc);
    res_en = 0; res_ci = 0; res_tag = 0; res_sel = 0; res_done = -1; res_idx = -1; res_vec = '1;
    @(posedge clk); #1;
    start[k] = 1'b1;
    for (int i = 1; i <= maxc; i++) begin
      @(posedge clk); #1;
      start[k] = extra && (i == 14 || done[k]);
      valid[k] = !(stall_n > 0 && i >= 25 && i < 25 + stall_n);
      rst[k]   = (i == rst_at);
      @(negedge clk);
      if (i == rst_at + 1) res_vec = act_vec(k);
      res_en  += int'(en[k]);
      res_ci  += int'(ciph[k]);
      res_tag += int'(tag[k]);
      res_sel += int'(sel[k]);
      if (ciph[k]) res_idx = int'(idx[k]);
      if (done[k]) begin
        res_done = i;
        break;
      end
    end
    @(posedge clk); #1;
    start[k] = 1'b0;
    valid[k] = 1'b1;
    rst[k]   = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    build(0, 1, 4);
    build(1, 2, 1);

    fork
      begin : cmp
        forever begin
          @(negedge clk);
          if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
              logic [22:0] a, e;
              a = act_vec(k);
              e = exp_vec(k);
              checks++;
              if (a !== e) begin
                errors++;
                $display("FAIL cycle_model inst%0d t=%0t: got %h, expected %h", k, $time, a, e);
              end
            end
          end
        end
      end
    join_none

    check("sched_len_default", len[0], 48);
    check("sched_len_ad2_pt1", len[1], 36);

    repeat (2) @(posedge clk);
    #1 rst = 2'b00;
    chk_on = 1'b1;
    @(negedge clk);
    check("reset_outputs", int'(act_vec(0)), 0);

    // plain run, default parameters
    do_run(0, 0, 1'b0, 0, 200);
    check("run_done_cycle", res_done, 49);
    check("run_enable_cycles", res_en, 48);
    check("run_cipher_count", res_ci, 4);
    check("run_tag_count", res_tag, 1);
    check("run_select_count", res_sel, 1);
    check("run_final_idx", res_idx, 3);

    // stall 3 cycles at PT block 1 absorb
    do_run(0, 3, 1'b0, 0, 200);
    check("stall_done_cycle", res_done, 52);
    check("stall_enable_cycles", res_en, 48);
    check("stall_cipher_count", res_ci, 4);

    // start pulsed in AD and in the DONE cycle
    do_run(0, 0, 1'b1, 0, 200);
    check("restart_done_cycle", res_done, 49);
    check("restart_enable_cycles", res_en, 48);
    @(negedge clk);
    check("restart_idle_after", int'(busy[0]), 0);

    // reset during FINAL rnd=5
    do_run(0, 0, 1'b0, 42, 100);
    check("abort_no_done", res_done, -1);
    check("abort_outputs_zero", int'(res_vec), 0);
    do_run(0, 0, 1'b0, 0, 200);
    check("after_abort_done_cycle", res_done, 49);
    check("after_abort_enable_cycles", res_en, 48);

    // NB_AD=2, NB_PT=1
    do_run(1, 0, 1'b0, 0, 200);
    check("ad2pt1_done_cycle", res_done, 37);
    check("ad2pt1_enable_cycles", res_en, 36);
    check("ad2pt1_cipher_count", res_ci, 1);
    check("ad2pt1_cipher_idx", res_idx, 0);
    check("ad2pt1_tag_count", res_tag, 1);

    // randomized starts, feeder stalls and occasional resets on both instances
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        start[k] = ($urandom_range(0, 15) == 0);
        valid[k] = ($urandom_range(0, 3) != 0);
        rst[k]   = ($urandom_range(0, 299) == 0);
      end
    end
    @(posedge clk); #1;
    start = 2'b00; valid = 2'b11; rst = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
